word_fetch_seq: RTL and testbench
=================================

Name: word_fetch_seq

Overview:
- Two-byte fetch sequencer that sits directly upstream of the 16-bit byte-writable register (PC / address / SP load path).
- On a start request it reads two consecutive bytes from the 8-bit memory bus with a req/ready handshake.
- It presents each byte on one shared byte bus with a one-cycle low- or high-half write enable, so the downstream register assembles the 16-bit word.
- Optional wait-state timeout reports a hung bus.

Parameters:
- HI_FIRST, 0: 0 = little-endian (low byte at addr, high at addr+1); 1 = high byte fetched first from addr.
- WAIT_LIMIT, 0: max consecutive not-ready cycles per byte before abort; 0 disables the timeout.
- WAIT_W, 8: width of the wait counter; WAIT_LIMIT must be < 2^WAIT_W.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a word fetch; sampled only in IDLE.
- startAddr  in  16  address of the first byte; latched when start is accepted.
- memReq  out  1  memory read request.
- memAddr  out  16  memory byte address.
- memRdata  in  8  memory read data; valid when memReady=1.
- memReady  in  1  memory has completed the current read.
- byteOut  out  8  fetched byte to the downstream register's data input.
- loWriteEn  out  1  one-cycle write strobe for the low half.
- hiWriteEn  out  1  one-cycle write strobe for the high half.
- busy  out  1  fetch in progress.
- done  out  1  one-cycle pulse when the sequence ends.
- timeoutErr  out  1  qualifies done; 1 = aborted by timeout.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, address latch 0x0000, wait counter 0.
- States:
  - IDLE: start=1 latches startAddr and goes to FETCH_A next cycle. busy=0, memReq=0.
  - FETCH_A: first byte. memReq=1, memAddr=latched addr, busy=1.
  - FETCH_B: second byte. memReq=1, memAddr=latched addr+1, busy=1.
  - FINISH: done=1 for exactly one cycle, busy=0, then IDLE.
- Handshake: a transfer completes on a rising edge where memReq=1 and memReady=1.
  - On that edge byteOut is registered from memRdata.
  - The matching write enable is asserted for the next cycle only.
  - Write-enable mapping: HI_FIRST=0 gives FETCH_A->loWriteEn and FETCH_B->hiWriteEn; HI_FIRST=1 swaps them.
  - FETCH_A goes to FETCH_B on that edge; FETCH_B goes to FINISH.
- Data ordering: the FETCH_B write strobe is high in the same cycle as done. The downstream register therefore holds the full word on the cycle after done.
- Wait states: while memReady=0, memReq and memAddr stay stable and the wait counter increments. The counter clears on each completed transfer and on entry to FETCH_A.
- Timeout:
  - If WAIT_LIMIT>0 and the counter equals WAIT_LIMIT with memReady still 0, go to FINISH with timeoutErr=1 for the done cycle.
  - No write enable is issued for the aborted byte.
  - A byte already written stays written; the downstream word is partially updated and the consumer must check timeoutErr.
- Address wrap: addr+1 is modulo 2^16, so 0xFFFF is followed by 0x0000.
- Minimum latency: start accepted at cycle 0 → FETCH_A at 1. With zero wait states, strobe A at 2, strobe B at 3, done at 3.
- Ignored inputs: start is ignored in FETCH_A, FETCH_B and FINISH. startAddr changes after acceptance have no effect.
- Back-to-back: start asserted in the cycle after done (state IDLE) is accepted.
- Reset mid-fetch: returns to IDLE next edge. Strobes in flight are suppressed, memReq drops, no done is issued.
- memReady=1 outside FETCH_A/FETCH_B is ignored.

Decomposition:
- Shared package: state enum (IDLE, FETCH_A, FETCH_B, FINISH), ADDR_W=16, DATA_W=8.
- One sub-module, fetch_wait_timer: clear/increment/limit-compare counter parameterised by WAIT_W and WAIT_LIMIT, with the limit compare tied off when WAIT_LIMIT=0.
- The FSM and byte steering live in the top module.

Test Plan:
- Reset, then start with startAddr=0x1234, memory 0x1234=0xCD and 0x1235=0xAB, zero wait states → loWriteEn carries byteOut=0xCD, then hiWriteEn carries 0xAB. done comes 3 cycles after start; the downstream word is 0xABCD the cycle after done.
- Same fetch with 2 wait states on each byte → memAddr held at 0x1234 then 0x1235 during the waits, done at cycle 7, no extra strobes.
- startAddr=0xFFFF → second request goes to memAddr=0x0000.
- HI_FIRST=1, startAddr=0x0040 holding 0x12, 0x0041 holding 0x34 → hiWriteEn carries 0x12 first, then loWriteEn carries 0x34; word=0x1234.
- WAIT_LIMIT=4, first byte completes and memReady is held low for the second → done with timeoutErr=1 after 4 wait cycles; only loWriteEn pulsed.
- Reset asserted during FETCH_B wait, and start pulsed while busy → no done and no hiWriteEn after reset; a start pulsed while busy does not begin a new fetch.

Source files
------------

// File: rtl/word_fetch_seq_pkg.sv
// word_fetch_seq_pkg: shared widths and FSM state encoding for the word fetch sequencer
package word_fetch_seq_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t FETCH_A = 2'd1;
  localparam state_t FETCH_B = 2'd2;
  localparam state_t FINISH  = 2'd3;
endpackage

// File: rtl/word_fetch_seq_if.sv
// word_fetch_seq_if: start/memory/byte-steering signals of the word fetch sequencer
interface word_fetch_seq_if;
  import word_fetch_seq_pkg::*;
  logic              start;
  logic [ADDR_W-1:0] startAddr;
  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memRdata;
  logic              memReady;
  logic [DATA_W-1:0] byteOut;
  logic              loWriteEn;
  logic              hiWriteEn;
  logic              busy;
  logic              done;
  logic              timeoutErr;
  modport master (
    input  start, startAddr, memRdata, memReady,
    output memReq, memAddr, byteOut, loWriteEn, hiWriteEn, busy, done, timeoutErr
  );
  modport slave (
    output start, startAddr, memRdata, memReady,
    input  memReq, memAddr, byteOut, loWriteEn, hiWriteEn, busy, done, timeoutErr
  );
endinterface

// File: rtl/word_fetch_seq_fetch_wait_timer.sv
// fetch_wait_timer: wait-state counter with limit compare, compare disabled when WAIT_LIMIT is 0
module fetch_wait_timer #(
  parameter int WAIT_W     = 8,
  parameter int WAIT_LIMIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);
  logic [WAIT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc) cnt <= cnt + WAIT_W'(1);
  end
  assign at_limit = (WAIT_LIMIT != 0) && (cnt == WAIT_W'(WAIT_LIMIT));
endmodule

// File: rtl/word_fetch_seq.sv
// word_fetch_seq: fetches two consecutive bytes and strobes them into the low/high halves of a 16-bit register
module word_fetch_seq
  import word_fetch_seq_pkg::*;
#(
  parameter bit HI_FIRST   = 1'b0,
  parameter int WAIT_LIMIT = 0,
  parameter int WAIT_W     = 8
) (
  input logic clk,
  input logic reset,
  word_fetch_seq_if.master bus
);
  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] byte_q;
  logic              stb_a, stb_b, tmo, xfer, abort, at_limit, accept;
  assign accept = (state == IDLE) && bus.start;
  assign xfer   = bus.memReq && bus.memReady;
  assign abort  = bus.memReq && !bus.memReady && at_limit;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = bus.start ? FETCH_A : IDLE;
    else if (state == FETCH_A) state_nx = xfer ? FETCH_B : abort ? FINISH : FETCH_A;
    else if (state == FETCH_B) state_nx = (xfer || abort) ? FINISH : FETCH_B;
    else state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr   <= '0;
      byte_q <= '0;
      stb_a  <= 1'b0;
      stb_b  <= 1'b0;
      tmo    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) addr <= bus.startAddr;
      if (xfer) byte_q <= bus.memRdata;
      stb_a <= xfer && (state == FETCH_A);
      stb_b <= xfer && (state == FETCH_B);
      tmo   <= abort;
    end
  end
  fetch_wait_timer #(.WAIT_W(WAIT_W), .WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .clr      (accept || xfer),
    .inc      (bus.memReq && !bus.memReady),
    .at_limit (at_limit)
  );
  assign bus.memReq     = (state == FETCH_A) || (state == FETCH_B);
  assign bus.memAddr    = (state == FETCH_B) ? addr + ADDR_W'(1) : (state == FETCH_A) ? addr : '0;
  assign bus.byteOut    = byte_q;
  assign bus.loWriteEn  = HI_FIRST ? stb_b : stb_a;
  assign bus.hiWriteEn  = HI_FIRST ? stb_a : stb_b;
  assign bus.busy       = bus.memReq;
  assign bus.done       = (state == FINISH);
  assign bus.timeoutErr = tmo;
endmodule

// File: tb/tb_word_fetch_seq.sv
// tb_word_fetch_seq: scoreboard bench for a little-endian/timeout instance and a high-first/no-timeout instance
module tb_word_fetch_seq;
  typedef struct {
    int          d;
    logic [15:0] v;
    logic        tmo;
    int          cyc;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0, cyc = 0;
  exp_t xq[$], lq[$], hq[$], dq[$];
  logic [1:0] st = '0, rdy = '0, hang = '0;
  logic [15:0] sa[2], hang_a[2], wreg[2], o_addr[2];
  logic [7:0] rd[2], o_byte[2];
  int waits[2], wc[2];
  logic [1:0] o_req, o_rdy, o_lo, o_hi, o_busy, o_done, o_tmo;

  word_fetch_seq_if b0 ();
  word_fetch_seq_if b1 ();

  word_fetch_seq #(.HI_FIRST(1'b0), .WAIT_LIMIT(4), .WAIT_W(8)) u0 (.clk(clk), .reset(rst), .bus(b0));
  word_fetch_seq #(.HI_FIRST(1'b1), .WAIT_LIMIT(0), .WAIT_W(8)) u1 (.clk(clk), .reset(rst), .bus(b1));

  assign b0.start = st[0];
  assign b1.start = st[1];
  assign b0.startAddr = sa[0];
  assign b1.startAddr = sa[1];
  assign b0.memReady = rdy[0];
  assign b1.memReady = rdy[1];
  assign b0.memRdata = rd[0];
  assign b1.memRdata = rd[1];
  assign o_req  = {b1.memReq, b0.memReq};
  assign o_rdy  = {b1.memReady, b0.memReady};
  assign o_lo   = {b1.loWriteEn, b0.loWriteEn};
  assign o_hi   = {b1.hiWriteEn, b0.hiWriteEn};
  assign o_busy = {b1.busy, b0.busy};
  assign o_done = {b1.done, b0.done};
  assign o_tmo  = {b1.timeoutErr, b0.timeoutErr};
  assign o_addr[0] = b0.memAddr;
  assign o_addr[1] = b1.memAddr;
  assign o_byte[0] = b0.byteOut;
  assign o_byte[1] = b1.byteOut;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h1234: return 8'hCD;
      16'h1235: return 8'hAB;
      16'hFFFF: return 8'h5A;
      16'h0000: return 8'hA5;
      16'h0040: return 8'h12;
      16'h0041: return 8'h34;
      default:  return a[7:0] ^ a[15:8];
    endcase
  endfunction

  function automatic exp_t mk(input int d, input logic [15:0] v, input logic tmo, input int c);
    exp_t e;
    e.d = d; e.v = v; e.tmo = tmo; e.cyc = c;
    return e;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endtask

  task automatic bad(input string n, input int d, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s unexpected on dut%0d actual=%0h required=none", n, d, act);
  endtask

  // memory model: answers after waits[d] not-ready cycles, never answers hang_a[d] while hang[d] is set
  initial begin
    waits[0] = 0; waits[1] = 0; wc[0] = 0; wc[1] = 0; rd[0] = '0; rd[1] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (o_req[d] === 1'b1 && !(hang[d] && o_addr[d] == hang_a[d]) && wc[d] >= waits[d]) begin
          rdy[d] = 1'b1; rd[d] = mem_rd(o_addr[d]); wc[d] = 0;
        end else begin
          rdy[d] = 1'b0; rd[d] = '0; wc[d] = (o_req[d] === 1'b1) ? wc[d] + 1 : 0;
        end
      end
    end
  end

  initial begin
    wreg[0] = '0; wreg[1] = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (o_req[d] === 1'b1 && xq.size() != 0 && xq[0].d == d) begin
          chk("req_addr", 32'(o_addr[d]), 32'(xq[0].v));
          if (o_rdy[d] === 1'b1) xq.delete(0);
        end else if (o_req[d] === 1'b1 && o_rdy[d] === 1'b1) bad("xfer", d, 32'(o_addr[d]));
        if (o_lo[d] === 1'b1) begin
          if (lq.size() != 0 && lq[0].d == d) begin
            chk("lo_byte", 32'(o_byte[d]), 32'(lq[0].v)); lq.delete(0);
          end else bad("lo_strobe", d, 32'(o_byte[d]));
          wreg[d][7:0] = o_byte[d];
        end
        if (o_hi[d] === 1'b1) begin
          if (hq.size() != 0 && hq[0].d == d) begin
            chk("hi_byte", 32'(o_byte[d]), 32'(hq[0].v)); hq.delete(0);
          end else bad("hi_strobe", d, 32'(o_byte[d]));
          wreg[d][15:8] = o_byte[d];
        end
        if (o_done[d] === 1'b1) begin
          if (dq.size() != 0 && dq[0].d == d) begin
            chk("done_cycle", 32'(cyc), 32'(dq[0].cyc));
            chk("done_tmo", 32'(o_tmo[d]), 32'(dq[0].tmo));
            chk("done_busy", 32'(o_busy[d]), 32'(0));
            chk("word", 32'(wreg[d]), 32'(dq[0].v));
            dq.delete(0);
          end else bad("done", d, 32'(cyc));
        end else if (o_tmo[d] === 1'b1) bad("tmo_without_done", d, 32'(1));
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 80 && dq.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (dq.size() != 0) begin
      bad("drain_timeout", dq[0].d, 32'(dq.size()));
      xq.delete(); lq.delete(); hq.delete(); dq.delete();
    end
  endtask

  // to: second byte hangs and is aborted (WAIT_LIMIT 4); poke: start pulsed again while busy
  task automatic fetch(input int d, input logic [15:0] a, input int w, input logic [15:0] word,
                       input bit to, input bit poke);
    logic [15:0] b;
    b = a + 16'd1;
    waits[d] = w; hang[d] = to; hang_a[d] = b;
    @(negedge clk);
    xq.push_back(mk(d, a, 1'b0, 0));
    if (d == 1) hq.push_back(mk(d, {8'h00, mem_rd(a)}, 1'b0, 0));
    else lq.push_back(mk(d, {8'h00, mem_rd(a)}, 1'b0, 0));
    if (!to) begin
      xq.push_back(mk(d, b, 1'b0, 0));
      if (d == 1) lq.push_back(mk(d, {8'h00, mem_rd(b)}, 1'b0, 0));
      else hq.push_back(mk(d, {8'h00, mem_rd(b)}, 1'b0, 0));
    end
    dq.push_back(mk(d, word, to, to ? cyc + 3 + w + 4 : cyc + 3 + 2 * w));
    st[d] = 1'b1; sa[d] = a;
    @(negedge clk);
    st[d] = poke; sa[d] = 16'h9999;
    @(negedge clk);
    st[d] = 1'b0; sa[d] = ~a;
    drain();
    hang[d] = 1'b0;
  endtask

  initial begin
    sa[0] = '0; sa[1] = '0; hang_a[0] = '0; hang_a[1] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ctl", 32'({o_req[d], o_busy[d], o_done[d], o_tmo[d], o_lo[d], o_hi[d]}), 32'(0));
      chk("reset_addr", 32'(o_addr[d]), 32'(0));
      chk("reset_byte", 32'(o_byte[d]), 32'(0));
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    fetch(0, 16'h1234, 0, 16'hABCD, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    fetch(0, 16'h1234, 2, 16'hABCD, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    fetch(0, 16'hFFFF, 0, 16'hA55A, 1'b0, 1'b0);
    fetch(0, 16'h1234, 0, 16'hABCD, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    fetch(0, 16'h2000, 0, 16'hAB20, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    // reset while the second byte is waiting, with a start pulsed during FETCH_B
    waits[0] = 0; hang[0] = 1'b1; hang_a[0] = 16'h3001;
    @(negedge clk);
    xq.push_back(mk(0, 16'h3000, 1'b0, 0));
    lq.push_back(mk(0, 16'h0030, 1'b0, 0));
    st[0] = 1'b1; sa[0] = 16'h3000;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b1; sa[0] = 16'h4444;
    @(negedge clk);
    st[0] = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; hang[0] = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("reset_mid_fetch", 32'({o_req[0], o_busy[0], o_done[0], o_lo[0], o_hi[0]}), 32'(0));
    chk("reset_mid_pending", 32'(xq.size() + lq.size() + hq.size()), 32'(0));
    fetch(1, 16'h0040, 0, 16'h1234, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    fetch(1, 16'h1234, 6, 16'hCDAB, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("leftover_expected", 32'(xq.size() + lq.size() + hq.size() + dq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
